alu_console: RTL and testbench

Single-clock, parametrised ALU console for the lab board. Operands A and B and opcode F are captured from the switch bus on synchronised, edge-detected button strobes, so the buttons no longer act as clocks. A registered ALU produces the result and four flags. A built-in multiplexed seven-segment driver shows the result, A or B in hex, with a view button to cycle between them. It replaces the per-button-clock ALU top level plus its separate display wrapper on the board top.

---
 rtl/alu_console.sv | 209 ++++++++++++++++++++
 tb/tb_alu_console.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_console.sv
// Single-clock ALU console: button-strobed operand capture, registered ALU and a muxed 7-seg driver.
// Define ALU_CONSOLE_MUL_EN to enable opcode 11 (single-cycle unsigned multiply).
module alu_console #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                      clk,
  input  logic                      clk_rst,
  input  logic                      btn_a,
  input  logic                      btn_b,
  input  logic                      btn_f,
  input  logic                      btn_view,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          res,
  output logic [3:0]                leds,
  output logic [$clog2(DIGITS)-1:0] which,
  output logic [7:0]                seg
);

  localparam int SHW = $clog2(WIDTH);
  localparam int WW  = $clog2(DIGITS);
  localparam int DW  = 4 * DIGITS;
  localparam int CW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] VIEW_RES = 2'd0;
  localparam logic [1:0] VIEW_A   = 2'd1;
  localparam logic [1:0] VIEW_B   = 2'd2;

  // Button bits: {view, f, b, a}
  logic [3:0] w_btn, r_s1, r_s2, r_s3, w_pulse;
  assign w_btn   = {btn_view, btn_f, btn_b, btn_a};
  assign w_pulse = r_s2 & ~r_s3;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_f;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_a <= '0;
      r_b <= '0;
      r_f <= '0;
    end else begin
      if (w_pulse[0]) r_a <= data_in;
      if (w_pulse[1]) r_b <= data_in;
      if (w_pulse[2]) r_f <= data_in[3:0];
    end
  end

  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sub, w_res;
  logic [SHW-1:0]   w_sh;
  logic             w_cf, w_of;
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = r_a - r_b;
  assign w_sh  = r_b[SHW-1:0];

`ifdef ALU_CONSOLE_MUL_EN
  logic [2*WIDTH-1:0] w_mul;
  assign w_mul = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`endif

  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    case (r_f)
      4'd0: w_res = r_a & r_b;
      4'd1: w_res = r_a | r_b;
      4'd2: w_res = r_a ^ r_b;
      4'd3: w_res = ~(r_a | r_b);
      4'd4: begin
        w_res = w_add[WIDTH-1:0];
        w_cf  = w_add[WIDTH];
        w_of  = (r_a[MSB] == r_b[MSB]) && (w_add[MSB] != r_a[MSB]);
      end
      4'd5: begin
        w_res = w_sub;
        w_cf  = (r_a < r_b);
        w_of  = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);
      end
      4'd6:  w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      4'd7:  w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      4'd8:  w_res = r_a << w_sh;
      4'd9:  w_res = r_a >> w_sh;
      4'd10: w_res = $unsigned($signed(r_a) >>> w_sh);
`ifdef ALU_CONSOLE_MUL_EN
      4'd11: begin
        w_res = w_mul[WIDTH-1:0];
        w_cf  = |w_mul[2*WIDTH-1:WIDTH];
      end
`endif
      default: w_res = '0;
    endcase
  end

  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_leds;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_res  <= '0;
      r_leds <= '0;
    end else begin
      r_res  <= w_res;
      r_leds <= {(w_res == '0), w_cf, w_of, w_res[MSB]};
    end
  end

  logic [1:0] r_view;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_view <= VIEW_RES;
    end else if (w_pulse[3]) begin
      case (r_view)
        VIEW_RES: r_view <= VIEW_A;
        VIEW_A:   r_view <= VIEW_B;
        default:  r_view <= VIEW_RES;
      endcase
    end
  end

  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_which, w_which_d;
  logic          w_wrap;
  assign w_wrap    = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_which_d = w_wrap ? r_which + 1'b1 : r_which;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      r_cnt   <= '0;
      r_which <= '0;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_which <= w_which_d;
    end
  end

  logic [WIDTH-1:0] w_view_val;
  logic [DW-1:0]    w_disp;
  logic [3:0]       w_nib;
  logic [6:0]       w_glyph;
  logic             w_dp;
  logic [7:0]       r_seg;

  always_comb begin
    case (r_view)
      VIEW_A:  w_view_val = r_a;
      VIEW_B:  w_view_val = r_b;
      default: w_view_val = r_res;
    endcase
  end

  if (WIDTH >= DW) begin : g_trunc
    assign w_disp = w_view_val[DW-1:0];
  end else begin : g_zext
    assign w_disp = {{(DW - WIDTH){1'b0}}, w_view_val};
  end

  // Segments are built from the next digit index so seg stays aligned with which.
  assign w_nib = w_disp[{w_which_d, 2'b00} +: 4];
  assign w_dp  = (w_which_d == '0) && (r_view != VIEW_RES);

  always_comb begin
    case (w_nib)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      default: w_glyph = 7'h71;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_rst) r_seg <= '0;
    else         r_seg <= {w_dp, w_glyph};
  end

  assign res   = r_res;
  assign leds  = r_leds;
  assign which = r_which;
  assign seg   = r_seg;

endmodule

// File: tb/tb_alu_console.sv
// Scoreboard bench for alu_console: stimulus queues timed expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_alu_console;

  logic        clk = 1'b0;
  logic        clk_rst = 1'b1;
  logic        btn_a = 1'b0, btn_b = 1'b0, btn_f = 1'b0, btn_view = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] res;
  logic [3:0]  leds;
  logic [2:0]  which;
  logic [7:0]  seg;

  alu_console #(
    .WIDTH      (32),
    .DIGITS     (8),
    .REFRESH_DIV(4)
  ) dut (
    .clk     (clk),
    .clk_rst (clk_rst),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .btn_f   (btn_f),
    .btn_view(btn_view),
    .data_in (data_in),
    .res     (res),
    .leds    (leds),
    .which   (which),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   c_rel = 0;

  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // sel: 0 res, 1 leds, 2 which, 3 seg
  function automatic void push(int c, int sel, logic [31:0] e, string nm);
    chk_t t;
    int   i;
    t.cyc = c; t.sel = sel; t.exp = e; t.name = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, t);
  endfunction

  always @(negedge clk) begin : monitor
    chk_t        t;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      t = q.pop_front();
      case (t.sel)
        0:       act = res;
        1:       act = {28'b0, leds};
        2:       act = {29'b0, which};
        default: act = {24'b0, seg};
      endcase
      n_total++;
      if (t.cyc != cyc)
        $display("FAIL %s: sample slot %0d missed (now %0d)", t.name, t.cyc, cyc);
      else if (act !== t.exp)
        $display("FAIL %s @cyc %0d: got %h, expected %h", t.name, cyc, act, t.exp);
      else
        n_pass++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int id, logic v);
    case (id)
      0:       btn_a = v;
      1:       btn_b = v;
      2:       btn_f = v;
      default: btn_view = v;
    endcase
  endtask

  task automatic press(int id, logic [31:0] d);
    data_in = d;
    set_btn(id, 1'b1);
    tick(3);
    set_btn(id, 1'b0);
    tick(3);
  endtask

  // F is pressed last; its edge is sampled at cyc+1, so res/leds settle after edge cyc+4.
  task automatic op(logic [31:0] a, logic [31:0] b, logic [3:0] f,
                    logic [31:0] er, logic [3:0] el, string nm);
    press(0, a);
    press(1, b);
    push(cyc + 4, 0, er, {nm, "_res"});
    push(cyc + 4, 1, {28'b0, el}, {nm, "_leds"});
    press(2, {28'b0, f});
  endtask

  task automatic check_frame(logic [31:0] val, logic dp, string nm);
    int n, w, nib;
    for (int j = 1; j <= 32; j++) begin
      n   = cyc + j;
      w   = ((n - c_rel) / 4) % 8;
      nib = int'((val >> (4 * w)) & 32'hF);
      push(n, 3, {24'b0, (w == 0) && dp, glyph[nib]}, {nm, "_seg"});
      push(n, 2, w, {nm, "_which"});
    end
    tick(34);
  endtask

  task automatic do_reset();
    int c;
    c = cyc;
    clk_rst = 1'b1;
    push(c + 1, 0, 32'h0, "rst_res");
    push(c + 1, 1, 32'h0, "rst_leds");
    push(c + 1, 2, 32'h0, "rst_which");
    tick(3);
    clk_rst = 1'b0;
    c_rel = cyc;
    push(c_rel + 1, 0, 32'h0, "post_rst_res");
    push(c_rel + 1, 1, 32'h8, "post_rst_leds");
    push(c_rel + 1, 2, 32'h0, "post_rst_which");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    tick(1);
    do_reset();
    tick(2);

    // OR with B=0 makes res mirror A
    push(cyc + 4, 0, 32'h0, "or_zero_res");
    press(2, 32'h1);

    c = cyc;
    data_in = 32'h12345678;
    btn_a   = 1'b1;
    push(c + 3, 0, 32'h0, "a_early");
    push(c + 4, 0, 32'h12345678, "a_latch");
    push(c + 4, 1, 32'h0, "a_latch_leds");
    tick(10);
    data_in = 32'hDEADBEEF;
    tick(40);
    push(cyc + 1, 0, 32'h12345678, "a_hold");
    btn_a = 1'b0;
    tick(3);
    check_frame(32'h12345678, 1'b0, "disp_nibbles");

    op(32'hFFFFFFFF, 32'h1,  4'd4,  32'h0,        4'b1100, "add_wrap");
    op(32'h80000000, 32'h1,  4'd5,  32'h7FFFFFFF, 4'b0010, "sub_ovf");
    push(cyc + 4, 0, 32'h1, "slt_res");
    push(cyc + 4, 1, 32'h0, "slt_leds");
    press(2, 32'h6);
    op(32'h80000000, 32'h24, 4'd10, 32'hF8000000, 4'b0001, "sra");
    op(32'h80000000, 32'h24, 4'd7,  32'h0,        4'b1000, "sltu");
    op(32'h1,        32'h2,  4'd5,  32'hFFFFFFFF, 4'b0101, "sub_borrow");
    op(32'hF0F0F0F0, 32'h4,  4'd8,  32'h0F0F0F00, 4'b0000, "sll");
`ifdef ALU_CONSOLE_MUL_EN
    op(32'h10000,    32'h10000, 4'd11, 32'h0, 4'b1100, "mul_hi");
`else
    op(32'h10000,    32'h10000, 4'd11, 32'h0, 4'b1000, "mul_off");
`endif
    op(32'h12345678, 32'hFFFF, 4'd15, 32'h0, 4'b1000, "unused_op");

    op(32'hA, 32'h0, 4'd1, 32'hA, 4'b0000, "disp_setup");
    check_frame(32'hA, 1'b0, "view_res");
    press(3, 32'h0);
    check_frame(32'hA, 1'b1, "view_a");
    press(3, 32'h0);
    check_frame(32'h0, 1'b1, "view_b");
    press(3, 32'h0);
    check_frame(32'hA, 1'b0, "view_res2");

    // Reset mid-operation with btn_a held through it: exactly one latch afterwards
    btn_a   = 1'b1;
    data_in = 32'h55;
    do_reset();
    tick(6);
    push(cyc + 4, 0, 32'h55, "held_rst_res");
    push(cyc + 4, 1, 32'h0, "held_rst_leds");
    press(2, 32'h1);
    btn_a = 1'b0;
    tick(3);

    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
